pe_mac_tree: RTL and testbench
==============================

// Module: pe_mac_tree
// PURPOSE
//   Parametrised multiply-accumulate processing element for the conv array.
//   - Multiplies LANES signed ifm/wgt pairs per beat and reduces them through a registered adder tree.
//   - Accumulates the tree sum over a multi-beat window delimited by in_first/in_last.
//   - Emits one p_sum per window with a single-cycle out_valid pulse.
//   - Sits between the ifm/wgt line buffers and the psum writeback path; stall comes from the array controller.
// PARAMETERS
//   LANES  4   multiplier lanes; power of 2, >= 2
//   DW     8   signed ifm/wgt element width
//   ACC_W  25  accumulator and p_sum width; must be >= 2*DW + log2(LANES)
// PORTS
//   clk        in   1            clock
//   rst_n      in   1            asynchronous, active-low reset
//   stall      in   1            freeze entire pipeline and accumulator
//   in_valid   in   1            ifm/wgt beat valid
//   in_first   in   1            beat opens a window (qualified by in_valid)
//   in_last    in   1            beat closes a window (qualified by in_valid)
//   ifm        in   LANES*DW     lane k = ifm[k*DW +: DW], signed
//   wgt        in   LANES*DW     lane k = wgt[k*DW +: DW], signed
//   out_valid  out  1            one-cycle pulse, p_sum holds a new result
//   p_sum      out  ACC_W        signed window result
// BEHAVIOUR
//   - Reset (async): all product, tree, valid/first/last sideband, acc, p_sum and out_valid registers clear to 0.
//   - S0 product stage: prod[k] <= ifm_k*wgt_k, 2*DW bits signed; flags registered alongside.
//   - Tree stages, T = log2(LANES) registered levels:
//     - level j adds adjacent pairs with 2*DW+j bits, sign-extended;
//     - sideband valid/first/last travel in lockstep with the data.
//   - Accumulate stage, on a valid tree output:
//     - acc_next = first ? sum : acc + sum (sum sign-extended to ACC_W);
//     - acc <= acc_next.
//     - If last: p_sum <= acc_next and out_valid <= 1. Otherwise out_valid <= 0.
//   - Latency: last beat sampled at edge N -> out_valid high after edge N+T+2. For LANES=4 that is 4 cycles.
//   - Throughput: one beat per cycle. No backpressure other than stall.
//   - stall=1:
//     - every register holds, including acc and p_sum;
//     - inputs are not sampled, so upstream holds its beat;
//     - out_valid is forced to 0 on that edge. A pulse is never repeated or extended.
//   - in_valid=0 beats are bubbles: the tree carries valid=0, and acc, p_sum and out_valid are unaffected.
//   - in_first && in_last on the same beat: single-beat window, p_sum = that beat's sum.
//   - Back-to-back windows, last followed by first on the next cycle: no bubble needed, no cross-contamination.
//   - Beat without in_first after reset or after last: adds onto the current acc. acc is 0 after reset; after last it holds the previous total.
//   - Overflow: acc wraps modulo 2^ACC_W in two's complement; no flag.
//   - Reset mid-window: partial acc and in-flight beats are discarded; the next window starts clean.
// CONFIGURATION
//   PE_RELU_EN defined:
//     - on the out_valid edge, p_sum <= (acc_next < 0) ? 0 : acc_next;
//     - acc keeps the unclamped value.
//   PE_RELU_EN undefined: p_sum is the raw signed acc_next.
// TESTING
//   All cases use LANES=4, DW=8, ACC_W=25.
//   1 single beat: ifm={1,2,3,4}, wgt={5,6,7,8}, first=last=1 -> out_valid 4 cycles later, p_sum=70.
//   2 extremes: all ifm=-128, wgt=-128, single beat -> p_sum=65536. ifm=-128, wgt=127 -> p_sum=-65024.
//   3 three-beat window of case-1 data, plus an in_valid=0 bubble between beats 2 and 3 -> one pulse, p_sum=210.
//   4 case 1 with stall high 2 cycles mid-flight:
//     - out_valid arrives 2 cycles later, p_sum=70;
//     - stall asserted on the pulse cycle drops the pulse after one cycle.
//   5 back-to-back single-beat windows A=70 then B (ifm={-1,-1,-1,-1}, wgt={1,2,3,4}):
//     - consecutive pulses 70, -10;
//     - with PE_RELU_EN: 70, 0.
//   6 rst_n pulsed low mid-window after 2 beats:
//     - all outputs read 0 immediately;
//     - next single-beat case-1 window -> p_sum=70.

Source files
------------

// File: rtl/pe_mac_tree.sv
// Multiply-accumulate PE: LANES signed products, registered adder tree, windowed accumulator.
// Optional PE_RELU_EN clamps negative window results to zero on p_sum only.
module pe_mac_tree #(
   parameter int LANES = 4,
   parameter int DW    = 8,
   parameter int ACC_W = 25
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     stall,
   input  logic                     in_valid,
   input  logic                     in_first,
   input  logic                     in_last,
   input  logic [LANES*DW-1:0]      ifm,
   input  logic [LANES*DW-1:0]      wgt,
   output logic                     out_valid,
   output logic signed [ACC_W-1:0]  p_sum
);

   localparam int T     = $clog2(LANES);
   localparam int TW    = 2*DW + T;
   localparam int NODES = 2*LANES - 1;

   // Tree nodes share one width; sign extension makes every level exact at TW bits.
   // Heap layout: root at 1, lane k's product at LANES+k, children of i at 2i/2i+1.
   logic [LANES*DW-1:0]     ifm_p0_q, ifm_p0_d;
   logic [LANES*DW-1:0]     wgt_p0_q, wgt_p0_d;
   logic                    vld_p0_q, vld_p0_d;
   logic                    first_p0_q, first_p0_d;
   logic                    last_p0_q, last_p0_d;
   logic signed [TW-1:0]    node_q [1:NODES];
   logic signed [TW-1:0]    node_d [1:NODES];
   logic [T:0]              tree_vld_q, tree_vld_d;
   logic [T:0]              tree_first_q, tree_first_d;
   logic [T:0]              tree_last_q, tree_last_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic signed [ACC_W-1:0] p_sum_q, p_sum_d;
   logic                    out_valid_q, out_valid_d;
   logic signed [ACC_W-1:0] acc_next;

   function automatic logic signed [TW-1:0] mul_lane(input logic signed [DW-1:0] a,
                                                     input logic signed [DW-1:0] b);
      logic signed [2*DW-1:0] p;
      p = a * b;
      return TW'(p);
   endfunction

   function automatic logic signed [ACC_W-1:0] sext_acc(input logic signed [TW-1:0] x);
      return ACC_W'(x);
   endfunction

   function automatic logic signed [ACC_W-1:0] result_of(input logic signed [ACC_W-1:0] x);
`ifdef PE_RELU_EN
      return (x < 0) ? '0 : x;
`else
      return x;
`endif
   endfunction

   always_comb begin
      ifm_p0_d     = ifm_p0_q;
      wgt_p0_d     = wgt_p0_q;
      vld_p0_d     = vld_p0_q;
      first_p0_d   = first_p0_q;
      last_p0_d    = last_p0_q;
      node_d       = node_q;
      tree_vld_d   = tree_vld_q;
      tree_first_d = tree_first_q;
      tree_last_d  = tree_last_q;
      acc_d        = acc_q;
      p_sum_d      = p_sum_q;
      out_valid_d  = 1'b0;
      acc_next     = tree_first_q[T] ? sext_acc(node_q[1])
                                     : acc_q + sext_acc(node_q[1]);
      if (!stall) begin
         // p0: input capture, flags qualified by in_valid
         ifm_p0_d   = ifm;
         wgt_p0_d   = wgt;
         vld_p0_d   = in_valid;
         first_p0_d = in_valid & in_first;
         last_p0_d  = in_valid & in_last;
         // tree level 0: lane products
         for (int k = 0; k < LANES; k++) begin
            node_d[LANES+k] = mul_lane(ifm_p0_q[k*DW +: DW], wgt_p0_q[k*DW +: DW]);
         end
         // tree levels 1..T: pairwise sums
         for (int i = 1; i < LANES; i++) begin
            node_d[i] = node_q[2*i] + node_q[2*i+1];
         end
         tree_vld_d   = {tree_vld_q[T-1:0], vld_p0_q};
         tree_first_d = {tree_first_q[T-1:0], first_p0_q};
         tree_last_d  = {tree_last_q[T-1:0], last_p0_q};
         // accumulate stage
         if (tree_vld_q[T]) begin
            acc_d = acc_next;
            if (tree_last_q[T]) begin
               p_sum_d     = result_of(acc_next);
               out_valid_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ifm_p0_q     <= '0;
         wgt_p0_q     <= '0;
         vld_p0_q     <= 1'b0;
         first_p0_q   <= 1'b0;
         last_p0_q    <= 1'b0;
         for (int n = 1; n <= NODES; n++) begin
            node_q[n] <= '0;
         end
         tree_vld_q   <= '0;
         tree_first_q <= '0;
         tree_last_q  <= '0;
         acc_q        <= '0;
         p_sum_q      <= '0;
         out_valid_q  <= 1'b0;
      end else begin
         ifm_p0_q     <= ifm_p0_d;
         wgt_p0_q     <= wgt_p0_d;
         vld_p0_q     <= vld_p0_d;
         first_p0_q   <= first_p0_d;
         last_p0_q    <= last_p0_d;
         node_q       <= node_d;
         tree_vld_q   <= tree_vld_d;
         tree_first_q <= tree_first_d;
         tree_last_q  <= tree_last_d;
         acc_q        <= acc_d;
         p_sum_q      <= p_sum_d;
         out_valid_q  <= out_valid_d;
      end
   end

   assign out_valid = out_valid_q;
   assign p_sum     = p_sum_q;

endmodule

// File: tb/tb_pe_mac_tree.sv
// Bench for pe_mac_tree (LANES=4, DW=8, ACC_W=25): directed cases plus randomized traffic
// against a window-sum model with a "result after 4 unstalled edges" timing rule.
module tb_pe_mac_tree;

   logic               clk;
   logic               rst_n;
   logic               stall;
   logic               in_valid;
   logic               in_first;
   logic               in_last;
   logic [31:0]        ifm;
   logic [31:0]        wgt;
   logic               out_valid;
   logic signed [24:0] p_sum;

   pe_mac_tree #(.LANES(4), .DW(8), .ACC_W(25)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .stall     (stall),
      .in_valid  (in_valid),
      .in_first  (in_first),
      .in_last   (in_last),
      .ifm       (ifm),
      .wgt       (wgt),
      .out_valid (out_valid),
      .p_sum     (p_sum)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // reference model state
   logic signed [24:0] model_acc;
   logic signed [24:0] pend_val [$];
   int                 pend_cnt [$];
   logic               exp_valid;
   logic signed [24:0] exp_psum;

   // observed pulses
   logic signed [24:0] obs_val [$];
   int                 obs_cyc [$];
   int                 beat_cyc;

   function automatic logic signed [24:0] relu_m(input logic signed [24:0] x);
`ifdef PE_RELU_EN
      return (x < 0) ? 25'sd0 : x;
`else
      return x;
`endif
   endfunction

   function automatic logic [31:0] pk(input int a0, input int a1, input int a2, input int a3);
      logic [7:0] b0, b1, b2, b3;
      b0 = 8'(a0); b1 = 8'(a1); b2 = 8'(a2); b3 = 8'(a3);
      return {b3, b2, b1, b0};
   endfunction

   function automatic int lane_sum(input logic [31:0] x, input logic [31:0] y);
      int s;
      logic signed [7:0] xa, yb;
      s = 0;
      for (int k = 0; k < 4; k++) begin
         xa = x[k*8 +: 8];
         yb = y[k*8 +: 8];
         s += int'(xa) * int'(yb);
      end
      return s;
   endfunction

   task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      model_acc = '0;
      pend_val.delete();
      pend_cnt.delete();
      exp_valid = 1'b0;
      exp_psum  = '0;
   endtask

   // Drive one cycle, advance the model by one edge, then check outputs.
   task automatic step(input bit v, input bit f, input bit l, input bit st,
                       input logic [31:0] a, input logic [31:0] w);
      int s;
      in_valid = v; in_first = f; in_last = l; stall = st; ifm = a; wgt = w;
      @(posedge clk);
      cyc++;
      exp_valid = 1'b0;
      if (!rst_n) begin
         model_reset();
      end else if (!st) begin
         foreach (pend_cnt[i]) pend_cnt[i]--;
         if (pend_cnt.size() > 0 && pend_cnt[0] == 0) begin
            exp_valid = 1'b1;
            exp_psum  = pend_val.pop_front();
            void'(pend_cnt.pop_front());
         end
         if (v) begin
            s = lane_sum(a, w);
            model_acc = f ? 25'(s) : model_acc + 25'(s);
            if (l) begin
               pend_val.push_back(relu_m(model_acc));
               pend_cnt.push_back(4);
            end
         end
      end
      #1;
      chk("out_valid", {63'd0, out_valid}, {63'd0, exp_valid});
      chk("p_sum", p_sum, exp_psum);
      if (out_valid === 1'b1) begin
         obs_val.push_back(p_sum);
         obs_cyc.push_back(cyc);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 32'd0, 32'd0);
   endtask

   task automatic clear_obs();
      obs_val.delete();
      obs_cyc.delete();
   endtask

   logic [31:0] a1, w1, am, wm, a5, aneg;

   initial begin
      a1   = pk(1, 2, 3, 4);
      w1   = pk(5, 6, 7, 8);
      am   = pk(-128, -128, -128, -128);
      wm   = pk(127, 127, 127, 127);
      a5   = pk(-1, -1, -1, -1);
      aneg = pk(1, 2, 3, 4);
      rst_n = 1'b0; stall = 1'b0; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
      ifm = '0; wgt = '0;
      model_reset();
      clear_obs();

      // reset state
      idle(2);
      chk("rst_out_valid", {63'd0, out_valid}, 64'sd0);
      chk("rst_p_sum", p_sum, 64'sd0);
      rst_n = 1'b1;
      idle(1);

      // case 1: single beat, latency 4
      clear_obs();
      step(1, 1, 1, 0, a1, w1); beat_cyc = cyc;
      idle(6);
      chk("c1_count", obs_val.size(), 1);
      if (obs_val.size() > 0) begin
         chk("c1_value", obs_val[0], 70);
         chk("c1_latency", obs_cyc[0] - beat_cyc, 4);
      end

      // case 2: extremes
      clear_obs();
      step(1, 1, 1, 0, am, am);
      idle(6);
      if (obs_val.size() > 0) chk("c2a_value", obs_val[0], 65536);
      chk("c2a_count", obs_val.size(), 1);
      clear_obs();
      step(1, 1, 1, 0, am, wm);
      idle(6);
      if (obs_val.size() > 0) chk("c2b_value", obs_val[0], relu_m(-25'sd65024));
      chk("c2b_count", obs_val.size(), 1);

      // case 3: three beats with a bubble
      clear_obs();
      step(1, 1, 0, 0, a1, w1);
      step(1, 0, 0, 0, a1, w1);
      step(0, 0, 0, 0, a1, w1);
      step(1, 0, 1, 0, a1, w1);
      idle(6);
      chk("c3_count", obs_val.size(), 1);
      if (obs_val.size() > 0) chk("c3_value", obs_val[0], 210);

      // case 4a: stall mid-flight delays the pulse
      clear_obs();
      step(1, 1, 1, 0, a1, w1); beat_cyc = cyc;
      idle(1);
      step(0, 0, 0, 1, 32'd0, 32'd0);
      step(0, 0, 0, 1, 32'd0, 32'd0);
      idle(6);
      chk("c4a_count", obs_val.size(), 1);
      if (obs_val.size() > 0) begin
         chk("c4a_value", obs_val[0], 70);
         chk("c4a_latency", obs_cyc[0] - beat_cyc, 6);
      end

      // case 4b: stall on the pulse cycle ends the pulse
      clear_obs();
      step(1, 1, 1, 0, a1, w1);
      idle(4);
      step(0, 0, 0, 1, 32'd0, 32'd0);
      chk("c4b_dropped", {63'd0, out_valid}, 64'sd0);
      chk("c4b_held", p_sum, 70);
      idle(4);
      chk("c4b_count", obs_val.size(), 1);

      // case 5: back-to-back windows
      clear_obs();
      step(1, 1, 1, 0, a1, w1);
      step(1, 1, 1, 0, a5, aneg);
      idle(6);
      chk("c5_count", obs_val.size(), 2);
      if (obs_val.size() == 2) begin
         chk("c5_first", obs_val[0], 70);
         chk("c5_second", obs_val[1], relu_m(-25'sd10));
         chk("c5_gap", obs_cyc[1] - obs_cyc[0], 1);
      end

      // case 6: reset mid-window
      clear_obs();
      step(1, 1, 0, 0, a1, w1);
      step(1, 0, 0, 0, a1, w1);
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("c6_async_valid", {63'd0, out_valid}, 64'sd0);
      chk("c6_async_psum", p_sum, 64'sd0);
      idle(1);
      rst_n = 1'b1;
      idle(6);
      chk("c6_discarded", obs_val.size(), 0);
      step(1, 1, 1, 0, a1, w1);
      idle(6);
      chk("c6_count", obs_val.size(), 1);
      if (obs_val.size() > 0) chk("c6_value", obs_val[0], 70);

      // beat without first after a window adds onto the held total
      clear_obs();
      step(1, 0, 1, 0, a1, w1);
      idle(6);
      if (obs_val.size() > 0) chk("nofirst_value", obs_val[0], 140);
      chk("nofirst_count", obs_val.size(), 1);

      // accumulator wrap: 300 beats of 65536
      clear_obs();
      for (int i = 0; i < 300; i++) step(1, i == 0, i == 299, 0, am, am);
      idle(6);
      chk("wrap_count", obs_val.size(), 1);
      if (obs_val.size() > 0) chk("wrap_value", obs_val[0], relu_m(-25'sd13893632));

      // randomized traffic with bubbles and stalls
      for (int i = 0; i < 600; i++) begin
         step($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
              $urandom_range(0, 9) == 0, $urandom, $urandom);
      end
      idle(8);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
